// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between N producer lanes, the round-robin mux stage and its consumer.
// The slave modport is the arbiter's view; the master modport is the producer/consumer side.
interface mux_rr_arbiter_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned SEL_WIDTH = 1
);
  localparam int unsigned NUM_INPUTS = 1 << SEL_WIDTH;

  logic [NUM_INPUTS-1:0]           i_valid;
  logic [NUM_INPUTS*BIT_WIDTH-1:0] i_inputs;
  logic [NUM_INPUTS-1:0]           o_ready;
  logic                            o_valid;
  logic [BIT_WIDTH-1:0]            o_outputs;
  logic [SEL_WIDTH-1:0]            o_sel;
  logic                            i_ready;

  modport master (
    output i_valid, i_inputs, i_ready,
    input  o_ready, o_valid, o_outputs, o_sel
  );

  modport slave (
    input  i_valid, i_inputs, i_ready,
    output o_ready, o_valid, o_outputs, o_sel
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin N-to-1 arbiter feeding a single-entry output buffer.
// The buffer reloads in the same cycle it drains, so one word per cycle is sustained.
module mux_rr_arbiter #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned SEL_WIDTH  = 1,
  parameter int unsigned NUM_INPUTS = 1 << SEL_WIDTH
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0] winner;
  logic                 any_valid;
  logic                 drain;
  logic                 can_load;
  logic                 load;

  // First valid requester scanning upward from ptr; index arithmetic wraps in SEL_WIDTH bits
  always_comb begin
    winner    = ptr_q;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (!any_valid && bus.i_valid[SEL_WIDTH'(ptr_q + SEL_WIDTH'(i))]) begin
        winner    = SEL_WIDTH'(ptr_q + SEL_WIDTH'(i));
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    data_d      = data_q;
    bus.o_ready = '0;
    drain       = (state_q == FULL) && bus.i_ready;
    can_load    = (state_q == EMPTY) || drain;
    load        = can_load && any_valid;

    // Reset gates ready so no handshake completes while the buffer is held clear
    if (load) begin
      bus.o_ready[winner] = i_rst_n;
      data_d              = bus.i_inputs[winner*BIT_WIDTH +: BIT_WIDTH];
      sel_d               = winner;
      ptr_d               = SEL_WIDTH'(winner + SEL_WIDTH'(1));
    end

    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (drain && !load) state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_valid   = (state_q == FULL);
  assign bus.o_outputs = data_q;
  assign bus.o_sel     = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a queue-based reference model predicts grants and words,
// a negedge monitor compares them against the DUT.
module tb_mux_rr_arbiter;
  localparam int unsigned BW = 16;
  localparam int unsigned SW = 2;
  localparam int unsigned N  = 1 << SW;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [SW-1:0] sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.BIT_WIDTH(BW), .SEL_WIDTH(SW)) bus ();

  mux_rr_arbiter #(.BIT_WIDTH(BW), .SEL_WIDTH(SW), .NUM_INPUTS(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  int           m_ptr  = 0;
  bit           m_full = 1'b0;
  bit           exp_valid = 1'b0;
  logic [N-1:0] exp_ready = '0;
  exp_t         sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the reference model, then wait past the next edge
  task automatic step(input logic [N-1:0] v, input logic [N*BW-1:0] words, input logic r);
    int w;
    bit drain, can;
    bus.i_valid  = v;
    bus.i_inputs = words;
    bus.i_ready  = r;
    exp_valid    = m_full;
    drain        = m_full && r;
    can          = !m_full || drain;
    w = -1;
    for (int j = 0; j < int'(N); j++)
      if (w < 0 && v[(m_ptr + j) % N]) w = (m_ptr + j) % N;
    exp_ready = '0;
    if (can && w >= 0) begin
      exp_ready[w] = 1'b1;
      sb.push_back('{data: words[w*BW +: BW], sel: SW'(w)});
      m_ptr  = (w + 1) % N;
      m_full = 1'b1;
    end else if (drain) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between edges; buffered word must vanish at once
  task automatic pulse_reset();
    bus.i_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_outputs", 32'(bus.o_outputs), 32'd0);
    chk("rst_o_sel", 32'(bus.o_sel), 32'd0);
    chk("rst_o_ready", 32'(bus.o_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    sb.delete();
    m_ptr     = 0;
    m_full    = 1'b0;
    exp_valid = 1'b0;
    exp_ready = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("o_ready", 32'(bus.o_ready), 32'(exp_ready));
      chk("o_valid", 32'(bus.o_valid), 32'(exp_valid));
      if (exp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got o_valid=1 expected a queued word at %0t", $time);
        end else begin
          chk("o_outputs", 32'(bus.o_outputs), 32'(sb[0].data));
          chk("o_sel", 32'(bus.o_sel), 32'(sb[0].sel));
          if (bus.i_ready) void'(sb.pop_front());
        end
      end
    end
  end

  logic [N*BW-1:0] w4;

  initial begin
    rst_n        = 1'b0;
    bus.i_valid  = '1;
    bus.i_inputs = {$urandom(), $urandom()};
    bus.i_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_o_valid", 32'(bus.o_valid), 32'd0);
    chk("init_o_outputs", 32'(bus.o_outputs), 32'd0);
    chk("init_o_sel", 32'(bus.o_sel), 32'd0);
    chk("init_o_ready", 32'(bus.o_ready), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // First transfer after reset goes to index 0
    step(4'b1111, {16'h3333, 16'h2222, 16'h1111, 16'h0F0F}, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Two-way alternation 0,1,0,1
    pulse_reset();
    repeat (4) step(4'b0011, {16'h0000, 16'h0000, 16'h5555, 16'hAAAA}, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Backpressure holds word and pointer
    step(4'b0010, {16'h0000, 16'h0000, 16'h1234, 16'h0000}, 1'b1);
    w4 = {16'hD004, 16'hC003, 16'hB002, 16'hA001};
    repeat (3) step(4'b1111, w4, 1'b0);
    step(4'b1111, w4, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Skip and wrap from ptr=3: grants 1,2,1
    step(4'b0100, {16'h0000, 16'h7777, 16'h0000, 16'h0000}, 1'b1);
    repeat (3) step(4'b0110, {16'h0000, 16'h2BAD, 16'h1BAD, 16'h0000}, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Idle cycles do not rotate priority
    step(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0E0E}, 1'b1);
    repeat (5) step(4'b0000, '0, 1'b1);
    step(4'b0011, {16'h0000, 16'h0000, 16'h1E1E, 16'h0E0E}, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Reset while FULL and stalled
    step(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hBEEF}, 1'b0);
    step(4'b0000, '0, 1'b0);
    pulse_reset();
    step(4'b1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1);

    // Random traffic with random backpressure
    repeat (400) step(N'($urandom()), {$urandom(), $urandom()}, ($urandom_range(3, 0) != 0));
    repeat (3) step(4'b0000, '0, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and output stage for a shared N-to-1 datapath mux. `NUM_INPUTS` requesters present data with valid/ready handshakes. The block picks one winner per transfer, drives the mux select, and registers the selected word into a single-entry output buffer with its own valid/ready handshake. It sits between producer lanes and a downstream consumer that can take only one word per cycle.

## Interface
- `BIT_WIDTH`, 16, width of each data word.
- `SEL_WIDTH`, 1, width of the select and grant index.
- `NUM_INPUTS`, `1 << SEL_WIDTH`, number of requesters. Must equal `2**SEL_WIDTH`.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  NUM_INPUTS  per-requester valid; bit k belongs to requester k.
- `i_inputs`  in  NUM_INPUTS*BIT_WIDTH  packed data; requester k occupies bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH].
- `o_ready`  out  NUM_INPUTS  per-requester accept; combinational, one-hot or zero.
- `o_valid`  out  1  output buffer holds a word.
- `o_outputs`  out  BIT_WIDTH  registered selected word.
- `o_sel`  out  SEL_WIDTH  registered index of the requester whose word is in `o_outputs`.
- `i_ready`  in  1  downstream accept.

## Operation
- State: output buffer status EMPTY/FULL (mirrored on `o_valid`), plus round-robin pointer `ptr` (SEL_WIDTH bits).
- `drain = o_valid & i_ready`.
- `can_load = !o_valid | drain`. This is a pass-through load: a new word can be loaded in the same cycle the old one drains.
- Winner: the first index k with `i_valid[k]=1`, scanning ptr, ptr+1, … mod NUM_INPUTS.
- `o_ready[winner] = can_load & |i_valid`; all other `o_ready` bits are 0. `o_ready` never depends on `i_ready` when the buffer is EMPTY.
- Load, when `can_load & |i_valid`:
  - `o_outputs` ← winner's word
  - `o_sel` ← winner
  - `o_valid` ← 1
  - `ptr` ← (winner+1) mod NUM_INPUTS; wraps from NUM_INPUTS-1 to 0.
- Drain without load: `o_valid` ← 0; `o_outputs` and `o_sel` hold their last values.
- FULL and no drain: all outputs hold, `o_ready` = 0, and `ptr` holds.
- No requests: `ptr` holds. Priority is not rotated by idle cycles.
- Transitions:
  - EMPTY → FULL on load.
  - FULL → FULL on drain+load, or on no drain.
  - FULL → EMPTY on drain with no request.
- Requesters may drop `i_valid` without a handshake. The arbiter re-evaluates every cycle and keeps no grant lock between transfers.

## Timing
- Reset values:
  - `o_valid`=0, `o_outputs`=0, `o_sel`=0, `ptr`=0, state EMPTY.
  - `o_ready` is all zeros during reset regardless of `i_valid`.
- Latency: a word accepted at edge N is visible on `o_outputs` with `o_valid`=1 immediately after edge N. It can be consumed at edge N+1.
- Throughput: one word per cycle sustained while `i_ready`=1.
- Fairness: with all requesters continuously valid and `i_ready`=1, grants cycle 0,1,…,N-1,0,… with no index repeated within N transfers.
- Reset asserted mid-transfer: the buffered word is discarded, outputs return to reset values asynchronously, and the pending handshake is not completed.
- After reset deassertion, the first load occurs at the first rising edge with `i_rst_n`=1 and any `i_valid` set.

## Test plan
- **Reset.** Assert `i_rst_n`=0 with `i_valid`=all ones → `o_valid`=0, `o_outputs`=0, `o_sel`=0, `o_ready`=0. Release reset → the first transfer goes to index 0.
- **Round robin, 2 inputs.** Both valid, words 0xAAAA/0x5555, `i_ready`=1 → `o_sel` sequence 0,1,0,1. `o_outputs` alternates 0xAAAA, 0x5555 at one word per cycle.
- **Backpressure.** Load 0x1234 from input 1, then hold `i_ready`=0 for 3 cycles → `o_outputs` stays 0x1234, `o_ready`=0, and `ptr` is unchanged. Raise `i_ready` → drain and next load in the same cycle.
- **Wrap and skip, SEL_WIDTH=2.** ptr=3 and only inputs 1 and 2 valid → grant order 1, 2, 1. ptr wraps 3→2→3→2.
- **Idle hold.** One transfer from input 0, then 5 idle cycles, then inputs 0 and 1 valid → input 1 wins first.
- **Reset mid-operation.** Buffer FULL holding 0xBEEF with `i_ready`=0; pulse `i_rst_n` low between edges → `o_valid` drops immediately, `o_outputs`=0, and the next grant starts from index 0.
